ic_mem_resp: RTL and testbench
==============================

Name: ic_mem_resp

Overview:
- Memory-side responder for the instruction-cache line-fill protocol.
- Accepts 16-byte line read requests tagged with a 2-bit transaction id (xid) and queues them in order.
- Fetches each line as four 32-bit beats from a word-wide backing memory read port, assembles the 128-bit line, and returns it with the originating xid as a single-cycle response pulse.
- Sits between the icache controller and the DRAM/PSRAM word port.

Parameters:
- QDEPTH, 4, request queue entries (power of 2, >=2); matches the 4 xids the cache can have outstanding.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- ic_mem_addr  in  [26:4]  line address of request
- ic_mem_xid  in  2  request transaction id
- ic_mem_re  in  1  request strobe; one request per cycle
- mem_ic_ready  out  1  a request presented next cycle will be accepted
- mem_ic_valid  out  1  response pulse, one cycle per line
- mem_ic_xid  out  2  xid of returned line
- mem_ic_data  out  128  returned line; word i at [i*32+:32]
- mem_req  out  1  backing read request
- mem_addr  out  [26:2]  backing word address
- mem_gnt  in  1  request accepted this cycle when mem_req=1
- mem_rvalid  in  1  read data valid; in order, latency >=1 cycle after gnt
- mem_rdata  in  32  read data
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low. All state clears immediately on rst_n low.
- Output values in reset:
  - mem_ic_valid=0, mem_ic_xid=0, mem_ic_data=0.
  - mem_req=0, mem_addr=0, proto_err=0.
  - Queue empty, FSM=IDLE, so mem_ic_ready=1.
- Ready rule (combinational): mem_ic_ready = (count + ic_mem_re) < QDEPTH. Pops are ignored, which keeps it conservative. ready=1 in cycle N guarantees acceptance of ic_mem_re in cycle N+1.
- Enqueue: when ic_mem_re=1 and the queue is not full, push {addr, xid} at the clock edge.
  - ic_mem_re while full: request dropped, proto_err<=1.
  - Simultaneous push and pop is legal; count is unchanged.
- Ordering: responses are strictly FIFO. Duplicate xids are served in order without checking.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: queue non-empty -> ISSUE; latch the head entry and clear gcnt and rcnt.
  - ISSUE:
    - mem_req=1 and mem_addr={head_addr, gcnt[1:0]}.
    - On each mem_gnt, gcnt increments.
    - On the 4th gnt: -> WAIT, or -> RESP directly if the 4th beat is also received that cycle.
  - Beat capture, valid in ISSUE or WAIT: each mem_rvalid writes mem_rdata into line word rcnt and increments rcnt. rvalid may overlap ISSUE.
  - WAIT: mem_req=0. When the 4th rvalid arrives -> RESP.
  - RESP:
    - mem_ic_valid=1 for exactly one cycle, with mem_ic_xid=head xid and mem_ic_data=assembled line.
    - The head is popped at the end of the cycle.
    - Next state: ISSUE if the queue still holds another entry, else IDLE.
    - There is no backpressure on responses.
- Registering: mem_ic_valid, mem_ic_xid and mem_ic_data are registered. Data holds its last value outside RESP; only the valid qualifies it.
- Stray data: mem_rvalid while no beat is outstanding (rcnt==gcnt, or state IDLE/RESP) is ignored and sets proto_err.
- Latency: request in cycle N, mem_gnt tied 1, read latency 1:
  - ISSUE in N+2..N+5;
  - rvalid in N+3..N+6;
  - mem_ic_valid in N+7.
- Reset mid-line: beats still returning after reset are treated as stray and set proto_err; no response is generated.
- Counters: gcnt and rcnt are 3 bits, range 0..4. The queue pointers wrap modulo QDEPTH.

Test Plan:
- Single request:
  - Stimulus: addr=0x00_1234 (23-bit), xid=2, gnt=1, latency 1, memory word value = word address.
  - Response: mem_addr sequence 0x48D0..0x48D3; mem_ic_valid pulse 7 cycles after re; xid=2; data={0x48D3,0x48D2,0x48D1,0x48D0}.
- Queue fill:
  - Stimulus: 4 requests xid 0..3 on consecutive cycles while ready=1.
  - Response: ready drops when count+re reaches 4; all four responses return in order 0,1,2,3 with correct lines.
- Overflow:
  - Stimulus: drive ic_mem_re with queue full.
  - Response: request dropped, proto_err=1 sticky, remaining responses unaffected.
- Backpressure and variable latency:
  - Stimulus: mem_gnt toggling 1/0; rvalid latencies 1,5,2,3.
  - Response: beats placed in order, single mem_ic_valid only after the 4th beat, mem_req never deasserted before the 4th gnt.
- Stray data:
  - Stimulus: mem_rvalid in IDLE.
  - Response: proto_err=1, no mem_ic_valid.
- Reset mid-line:
  - Stimulus: async reset during ISSUE with 2 beats outstanding.
  - Response: all outputs 0 immediately, ready=1; after reset, late rvalid sets proto_err and no response is generated; a fresh request completes normally.

Source files
------------

// File: rtl/ic_mem_resp.sv
// Memory-side responder for icache line fills: queues line requests in order, fetches four
// word beats per line from the backing port and returns each assembled line as a one-cycle pulse.
module ic_mem_resp #(
    parameter int unsigned QDEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [26:4]   ic_mem_addr,
    input  logic [1:0]    ic_mem_xid,
    input  logic          ic_mem_re,
    output logic          mem_ic_ready,
    output logic          mem_ic_valid,
    output logic [1:0]    mem_ic_xid,
    output logic [127:0]  mem_ic_data,
    output logic          mem_req,
    output logic [26:2]   mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    output logic          proto_err
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned RW = CW + 1;

    typedef struct packed {
        logic [22:0] addr;
        logic [1:0]  xid;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    req_t               q [QDEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      head_ptr;
    logic [CW-1:0]      count;

    state_t             state;
    state_t             state_d;
    logic [2:0]         gcnt;
    logic [2:0]         gcnt_d;
    logic [2:0]         rcnt;
    logic [2:0]         rcnt_d;
    logic [3:0][31:0]   line;
    logic [3:0][31:0]   line_d;
    req_t               head;
    req_t               head_d;

    logic               full;
    logic               push;
    logic               pop;
    logic               load_head;
    logic               beat_ok;
    logic               stray;

    // Conservative ready: ignores a pop in the same cycle
    assign full         = (count == CW'(QDEPTH));
    assign push         = ic_mem_re && !full;
    assign mem_ic_ready = (RW'(count) + RW'(ic_mem_re)) < RW'(QDEPTH);

    // Next-state, beat capture and head selection
    always_comb begin
        state_d   = state;
        gcnt_d    = gcnt;
        rcnt_d    = rcnt;
        line_d    = line;
        head_d    = head;
        pop       = 1'b0;
        load_head = 1'b0;
        beat_ok   = ((state == ISSUE) || (state == WAIT)) && (rcnt < gcnt);
        stray     = mem_rvalid && !beat_ok;

        if (mem_rvalid && beat_ok) begin
            line_d[rcnt[1:0]] = mem_rdata;
            rcnt_d            = rcnt + 3'd1;
        end

        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_d   = ISSUE;
                    load_head = 1'b1;
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    gcnt_d = gcnt + 3'd1;
                    if (gcnt == 3'd3) begin
                        state_d = (rcnt_d == 3'd4) ? RESP : WAIT;
                    end
                end
            end
            WAIT: begin
                if (rcnt_d == 3'd4) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                pop = 1'b1;
                if (count > CW'(1)) begin
                    state_d   = ISSUE;
                    load_head = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        head_ptr = pop ? (rd_ptr + PW'(1)) : rd_ptr;
        if (load_head) begin
            head_d = q[head_ptr];
            gcnt_d = 3'd0;
            rcnt_d = 3'd0;
        end
    end

    // FSM state, counters, line buffer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            gcnt         <= 3'd0;
            rcnt         <= 3'd0;
            line         <= '0;
            head         <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            mem_ic_valid <= 1'b0;
            mem_ic_xid   <= 2'd0;
            mem_ic_data  <= '0;
            proto_err    <= 1'b0;
        end else begin
            state        <= state_d;
            gcnt         <= gcnt_d;
            rcnt         <= rcnt_d;
            line         <= line_d;
            head         <= head_d;
            mem_req      <= (state_d == ISSUE);
            mem_ic_valid <= (state_d == RESP);
            if (state_d == ISSUE) begin
                mem_addr <= {head_d.addr, gcnt_d[1:0]};
            end
            if (state_d == RESP) begin
                mem_ic_xid  <= head_d.xid;
                mem_ic_data <= line_d;
            end
            if ((ic_mem_re && full) || stray) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Request queue storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
                q[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q[wr_ptr] <= '{addr: ic_mem_addr, xid: ic_mem_xid};
                wr_ptr    <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ic_mem_resp.sv
// Directed bench for ic_mem_resp: behavioural word memory with per-beat latency,
// response scoreboard, and hand-computed checks of ready, proto_err and latency.
module tb_ic_mem_resp;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [26:4]   ic_mem_addr = '0;
    logic [1:0]    ic_mem_xid = '0;
    logic          ic_mem_re = 1'b0;
    logic          mem_ic_ready;
    logic          mem_ic_valid;
    logic [1:0]    mem_ic_xid;
    logic [127:0]  mem_ic_data;
    logic          mem_req;
    logic [26:2]   mem_addr;
    logic          mem_gnt = 1'b1;
    logic          mem_rvalid = 1'b0;
    logic [31:0]   mem_rdata = '0;
    logic          proto_err;

    ic_mem_resp #(.QDEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ic_mem_addr  (ic_mem_addr),
        .ic_mem_xid   (ic_mem_xid),
        .ic_mem_re    (ic_mem_re),
        .mem_ic_ready (mem_ic_ready),
        .mem_ic_valid (mem_ic_valid),
        .mem_ic_xid   (mem_ic_xid),
        .mem_ic_data  (mem_ic_data),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [22:0] a;
        logic [1:0]  x;
    } exp_t;

    typedef struct {
        logic [24:0] a;
        int          due;
    } beat_t;

    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    int           resp_cnt = 0;
    int           last_resp_cyc = 0;
    int           last_rv_cyc = -1;
    int           gnt_total = 0;
    int           drop_err = 0;
    int           lat_tab [4] = '{1, 1, 1, 1};
    logic         gnt_toggle = 1'b0;
    logic         stray_req = 1'b0;
    logic         prev_req = 1'b0;
    exp_t         exp_q [$];
    beat_t        pend [$];
    logic [24:0]  gnt_log [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] line_of(input logic [22:0] a);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*32 +: 32] = 32'({a, 2'(i)});
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Response scoreboard followed by the backing-memory model
    always @(negedge clk) begin
        exp_t  e;
        beat_t b;
        if (mem_ic_valid) begin
            resp_cnt++;
            last_resp_cyc = cyc;
            check("resp_expected", 128'(exp_q.size() != 0), 128'd1);
            check("resp_after_beat4", 128'(cyc > last_rv_cyc), 128'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("resp_xid", 128'(mem_ic_xid), 128'(e.x));
                check("resp_data", mem_ic_data, line_of(e.a));
            end
        end
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (stray_req) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
            stray_req  = 1'b0;
        end else if (pend.size() != 0 && pend[0].due <= cyc) begin
            b = pend.pop_front();
            mem_rvalid  = 1'b1;
            mem_rdata   = 32'(b.a);
            last_rv_cyc = cyc;
        end
        mem_gnt = gnt_toggle ? cyc[0] : 1'b1;
        if (prev_req && !mem_req && (gnt_total % 4) != 0) drop_err++;
        prev_req = mem_req;
        if (mem_req && mem_gnt) begin
            pend.push_back('{a: mem_addr, due: cyc + lat_tab[gnt_total % 4]});
            gnt_log.push_back(mem_addr);
            gnt_total++;
        end
    end

    task automatic send(input logic [22:0] a, input logic [1:0] x, output int when);
        @(negedge clk);
        ic_mem_re   = 1'b1;
        ic_mem_addr = a;
        ic_mem_xid  = x;
        exp_q.push_back('{a: a, x: x});
        when = cyc;
        @(negedge clk);
        ic_mem_re = 1'b0;
    endtask

    task automatic wait_resp(input int n);
        for (int i = 0; i < 300 && resp_cnt < n; i++) @(negedge clk);
        #1;
        check("resp_count", 128'(resp_cnt), 128'(n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
        lat_tab[0] = l0;
        lat_tab[1] = l1;
        lat_tab[2] = l2;
        lat_tab[3] = l3;
    endtask

    initial begin
        int req_cyc;
        int gbase;
        int d0;
        int base;
        logic [22:0] a;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 128'(mem_ic_valid), 128'd0);
        check("rst_xid", 128'(mem_ic_xid), 128'd0);
        check("rst_data", mem_ic_data, 128'd0);
        check("rst_req", 128'(mem_req), 128'd0);
        check("rst_addr", 128'(mem_addr), 128'd0);
        check("rst_proto_err", 128'(proto_err), 128'd0);
        check("rst_ready", 128'(mem_ic_ready), 128'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single request, memory word = word address
        gbase = gnt_log.size();
        send(23'h001234, 2'd2, req_cyc);
        wait_resp(1);
        check("single_latency", 128'(last_resp_cyc - req_cyc), 128'd7);
        for (int i = 0; i < 4; i++) begin
            check("single_mem_addr", 128'(gnt_log[gbase + i]), 128'(25'h48D0 + 25'(i)));
        end
        check("single_proto_err", 128'(proto_err), 128'd0);

        // queue fill then overflow
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = 23'h100 + 23'(i) * 23'h11;
            ic_mem_re   = 1'b1;
            ic_mem_addr = a;
            ic_mem_xid  = 2'(i);
            exp_q.push_back('{a: a, x: 2'(i)});
            #1 check("fill_ready", 128'(mem_ic_ready), (i == 3) ? 128'd0 : 128'd1);
        end
        @(negedge clk);
        ic_mem_addr = 23'h7FF;
        ic_mem_xid  = 2'd1;
        #1 check("full_ready", 128'(mem_ic_ready), 128'd0);
        @(negedge clk);
        ic_mem_re = 1'b0;
        #1;
        check("ovf_proto_err", 128'(proto_err), 128'd1);
        check("full_ready_idle", 128'(mem_ic_ready), 128'd0);
        wait_resp(5);
        check("fill_queue_drained", 128'(exp_q.size()), 128'd0);

        // grant backpressure with latencies 1,5,2,3
        repeat (3) @(negedge clk);
        gnt_toggle = 1'b1;
        set_lat(1, 5, 2, 3);
        d0 = drop_err;
        send(23'h07ABCD, 2'd1, req_cyc);
        wait_resp(6);
        repeat (5) @(negedge clk);
        #1;
        check("bp_single_valid", 128'(resp_cnt), 128'd6);
        check("bp_no_req_drop", 128'(drop_err - d0), 128'd0);
        check("bp_proto_err_sticky", 128'(proto_err), 128'd1);
        gnt_toggle = 1'b0;
        set_lat(1, 1, 1, 1);

        // stray read data while idle
        do_reset();
        #1 check("stray_pre_proto_err", 128'(proto_err), 128'd0);
        @(negedge clk);
        #2 stray_req = 1'b1;
        repeat (2) @(negedge clk);
        #1 check("stray_proto_err", 128'(proto_err), 128'd1);
        repeat (4) @(negedge clk);
        #1 check("stray_no_resp", 128'(resp_cnt), 128'd6);

        // async reset with two beats outstanding
        do_reset();
        set_lat(4, 4, 4, 4);
        base = gnt_total;
        send(23'h000ABC, 2'd3, req_cyc);
        for (int i = 0; i < 50 && gnt_total < base + 2; i++) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_valid", 128'(mem_ic_valid), 128'd0);
        check("mid_rst_req", 128'(mem_req), 128'd0);
        check("mid_rst_addr", 128'(mem_addr), 128'd0);
        check("mid_rst_data", mem_ic_data, 128'd0);
        check("mid_rst_proto_err", 128'(proto_err), 128'd0);
        check("mid_rst_ready", 128'(mem_ic_ready), 128'd1);
        check("mid_rst_outstanding", 128'(pend.size()), 128'd2);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("late_beat_proto_err", 128'(proto_err), 128'd1);
        check("mid_rst_no_resp", 128'(resp_cnt), 128'd6);
        set_lat(1, 1, 1, 1);
        send(23'h055555, 2'd0, req_cyc);
        wait_resp(7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
